// File: rtl/ghost_motion_unit.sv
// Red-ghost controller: one-second tick, LFSR direction picker and
// frame-stepped position engine with wall blocking and screen clamping.
module ghost_motion_unit #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned START_X   = 320,
  parameter int unsigned START_Y   = 240,
  parameter int unsigned SIZE      = 13,
  parameter int unsigned STEP      = 1,
  parameter int unsigned X_MAX     = 639,
  parameter int unsigned Y_MAX     = 479,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        lifeDown,
  input  logic        restart,
  input  logic [4:0]  mapL,
  input  logic [4:0]  mapR,
  input  logic [4:0]  mapT,
  input  logic [4:0]  mapB,
  output logic [9:0]  redghostX,
  output logic [9:0]  redghostY,
  output logic [9:0]  redghostS,
  output logic [7:0]  randomkeycode,
  output logic        sec,
  output logic [31:0] counter_out
);

  localparam int unsigned PW = 10;
  localparam int unsigned CW = 32;
  localparam int unsigned LW = 16;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_HZ - 1);

  localparam logic [PW-1:0] X_START   = PW'(START_X);
  localparam logic [PW-1:0] Y_START   = PW'(START_Y);
  localparam logic [PW-1:0] STEP_V    = PW'(STEP);
  localparam logic [PW-1:0] X_LO      = PW'(SIZE);
  localparam logic [PW-1:0] X_HI      = PW'(X_MAX - SIZE);
  localparam logic [PW-1:0] Y_LO      = PW'(SIZE);
  localparam logic [PW-1:0] Y_HI      = PW'(Y_MAX - SIZE);
  // Thresholds compared before any add/subtract so nothing wraps.
  localparam logic [PW-1:0] X_LO_STEP = PW'(SIZE + STEP);
  localparam logic [PW-1:0] Y_LO_STEP = PW'(SIZE + STEP);
  localparam logic [PW-1:0] X_HI_STEP = PW'(X_MAX - SIZE - STEP);
  localparam logic [PW-1:0] Y_HI_STEP = PW'(Y_MAX - SIZE - STEP);

  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_RIGHT = 8'h07;

  logic [LW-1:0] lfsr;
  logic [LW-1:0] lfsr_next_c;
  logic          frame_d;
  logic          move_stb_c;
  logic [7:0]    key_pick_c;
  logic [PW-1:0] x_next_c;
  logic [PW-1:0] y_next_c;

  assign redghostS = PW'(SIZE);

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
  assign lfsr_next_c = {lfsr[LW-2:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign move_stb_c  = frame_clk & ~frame_d;

  always_comb begin
    key_pick_c = KEY_RIGHT;
    case (lfsr[1:0])
      2'b00:   key_pick_c = KEY_UP;
      2'b01:   key_pick_c = KEY_LEFT;
      2'b10:   key_pick_c = KEY_DOWN;
      default: key_pick_c = KEY_RIGHT;
    endcase
  end

  // Next position: start override, otherwise one blocked/clamped step.
  always_comb begin
    x_next_c = redghostX;
    y_next_c = redghostY;
    if (lifeDown || restart) begin
      x_next_c = X_START;
      y_next_c = Y_START;
    end else if (move_stb_c) begin
      case (randomkeycode)
        KEY_UP: begin
          if (mapT == 5'd0)
            y_next_c = (redghostY < Y_LO_STEP) ? Y_LO : redghostY - STEP_V;
        end
        KEY_DOWN: begin
          if (mapB == 5'd0)
            y_next_c = (redghostY > Y_HI_STEP) ? Y_HI : redghostY + STEP_V;
        end
        KEY_LEFT: begin
          if (mapL == 5'd0)
            x_next_c = (redghostX < X_LO_STEP) ? X_LO : redghostX - STEP_V;
        end
        KEY_RIGHT: begin
          if (mapR == 5'd0)
            x_next_c = (redghostX > X_HI_STEP) ? X_HI : redghostX + STEP_V;
        end
        default: begin
          x_next_c = redghostX;
          y_next_c = redghostY;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      counter_out   <= '0;
      sec           <= 1'b0;
      lfsr          <= LFSR_SEED;
      randomkeycode <= KEY_RIGHT;
      frame_d       <= 1'b0;
      redghostX     <= X_START;
      redghostY     <= Y_START;
    end else begin
      if (counter_out == CNT_LAST) begin
        counter_out <= '0;
        sec         <= 1'b1;
      end else begin
        counter_out <= counter_out + CW'(1);
        sec         <= 1'b0;
      end
      lfsr <= lfsr_next_c;
      if (sec)
        randomkeycode <= key_pick_c;
      frame_d   <= frame_clk;
      redghostX <= x_next_c;
      redghostY <= y_next_c;
    end
  end

endmodule

// File: tb/tb_ghost_motion_unit.sv
// Directed bench for ghost_motion_unit with CLK_HZ=8 and a reference
// LFSR/keycode model used to time frame strobes against the direction.
module tb_ghost_motion_unit;

  localparam logic [7:0] K_UP    = 8'h1A;
  localparam logic [7:0] K_LEFT  = 8'h04;
  localparam logic [7:0] K_DOWN  = 8'h16;
  localparam logic [7:0] K_RIGHT = 8'h07;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_clk = 1'b0;
  logic        lifeDown = 1'b0;
  logic        restart = 1'b0;
  logic [4:0]  mapL = '0, mapR = '0, mapT = '0, mapB = '0;
  logic [9:0]  redghostX, redghostY, redghostS;
  logic [7:0]  randomkeycode;
  logic        sec;
  logic [31:0] counter_out;

  int tests = 0;
  int fails = 0;

  ghost_motion_unit #(.CLK_HZ(8)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .lifeDown(lifeDown),
    .restart(restart), .mapL(mapL), .mapR(mapR), .mapT(mapT), .mapB(mapB),
    .redghostX(redghostX), .redghostY(redghostY), .redghostS(redghostS),
    .randomkeycode(randomkeycode), .sec(sec), .counter_out(counter_out)
  );

  always #5 Clk = ~Clk;

  // Reference direction model: second tick plus x^16+x^14+x^13+x^11+1 LFSR.
  logic [3:0]  m_cnt;
  logic        m_sec;
  logic [15:0] m_lfsr;
  logic [7:0]  m_key;
  logic [7:0]  key_tab [4] = '{K_UP, K_LEFT, K_DOWN, K_RIGHT};

  always @(posedge Clk) begin
    if (!Reset) begin
      m_cnt  <= 4'd0;
      m_sec  <= 1'b0;
      m_lfsr <= 16'hACE1;
      m_key  <= K_RIGHT;
    end else begin
      m_cnt  <= (m_cnt == 4'd7) ? 4'd0 : m_cnt + 4'd1;
      m_sec  <= (m_cnt == 4'd7);
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      if (m_sec)
        m_key <= key_tab[m_lfsr[1:0]];
    end
  end

  // Issue n rising frame edges, each while the model direction equals key.
  task automatic move(input logic [7:0] key, input int n);
    int done = 0;
    int guard = 0;
    while (done < n && guard < 20000) begin
      @(negedge Clk);
      guard++;
      if (frame_clk) frame_clk = 1'b0;
      else if (m_key == key) begin
        frame_clk = 1'b1;
        done++;
      end
    end
    @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    if (done < n) begin
      tests++; fails++;
      $display("FAIL move_timeout key=%h issued=%0d required=%0d", key, done, n);
    end
  endtask

  task automatic check_pos(input string name, input logic [9:0] ex, input logic [9:0] ey);
    tests++;
    if (redghostX !== ex || redghostY !== ey) begin
      fails++;
      $display("FAIL %s pos=(%0d,%0d) required=(%0d,%0d)", name, redghostX, redghostY, ex, ey);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    tests++;
    if (counter_out !== 32'd0 || sec !== 1'b0 || randomkeycode !== K_RIGHT || redghostS !== 10'd13) begin
      fails++;
      $display("FAIL reset cnt=%0d sec=%b key=%h S=%0d required 0 0 07 13",
               counter_out, sec, randomkeycode, redghostS);
    end
    check_pos("reset_pos", 10'd320, 10'd240);
  endtask

  task automatic test_second_counter;
    Reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      tests++;
      if (counter_out !== 32'(k % 8) || sec !== ((k % 8) == 0)) begin
        fails++;
        $display("FAIL counter k=%0d cnt=%0d sec=%b required cnt=%0d sec=%b",
                 k, counter_out, sec, k % 8, (k % 8) == 0);
      end
    end
    Reset = 1'b0;
    @(negedge Clk);
    tests++;
    if (counter_out !== 32'd0 || sec !== 1'b0 || randomkeycode !== K_RIGHT) begin
      fails++;
      $display("FAIL mid_reset cnt=%0d sec=%b key=%h required 0 0 07", counter_out, sec, randomkeycode);
    end
    Reset = 1'b1;
  endtask

  task automatic test_random_dir;
    int changes = 0;
    logic [7:0] prev = K_RIGHT;
    for (int i = 0; i < 80; i++) begin
      @(negedge Clk);
      tests++;
      if (randomkeycode !== m_key) begin
        fails++;
        $display("FAIL random_dir cycle=%0d key=%h required=%h", i, randomkeycode, m_key);
      end
      if (m_key != prev) changes++;
      prev = m_key;
    end
    tests++;
    if (changes == 0) begin
      fails++;
      $display("FAIL random_dir_changes observed=0 required>0");
    end
  endtask

  task automatic test_move_right;
    move(K_RIGHT, 5);
    check_pos("move_right", 10'd325, 10'd240);
    tests++;
    if (redghostS !== 10'd13) begin
      fails++;
      $display("FAIL size S=%0d required=13", redghostS);
    end
  endtask

  task automatic test_wall_block;
    mapR = 5'b00100;
    move(K_RIGHT, 3);
    check_pos("wall_right_blocked", 10'd325, 10'd240);
    mapR = 5'b00000;
    mapL = 5'b11111;
    move(K_RIGHT, 1);
    check_pos("other_wall_ignored", 10'd326, 10'd240);
    mapL = 5'b00000;
  endtask

  task automatic test_frame_hold;
    int guard = 0;
    @(negedge Clk);
    while (m_key != K_RIGHT && guard < 20000) begin
      @(negedge Clk);
      guard++;
    end
    frame_clk = 1'b1;
    repeat (100) @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    check_pos("frame_hold_one_step", 10'd327, 10'd240);
  endtask

  task automatic test_left_clamp;
    move(K_LEFT, 307);
    check_pos("left_to_20", 10'd20, 10'd240);
    move(K_LEFT, 8);
    check_pos("left_clamp_8", 10'd13, 10'd240);
    move(K_LEFT, 2);
    check_pos("left_clamp_hold", 10'd13, 10'd240);
  endtask

  task automatic test_back_to_back;
    // lifeDown wins over a simultaneous rising frame edge
    @(negedge Clk);
    lifeDown  = 1'b1;
    frame_clk = 1'b1;
    @(negedge Clk);
    lifeDown  = 1'b0;
    frame_clk = 1'b0;
    check_pos("lifedown_override", 10'd320, 10'd240);
    mapB = 5'b00001;
    move(K_UP, 2);
    check_pos("move_up", 10'd320, 10'd238);
    move(K_DOWN, 2);
    check_pos("down_blocked", 10'd320, 10'd238);
    mapB = 5'b00000;
    restart = 1'b1;
    @(negedge Clk);
    restart = 1'b0;
    check_pos("restart", 10'd320, 10'd240);
  endtask

  initial begin
    test_reset;
    test_second_counter;
    test_random_dir;
    test_move_right;
    test_wall_block;
    test_frame_hold;
    test_left_clamp;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ghost_motion_unit.md
Name: ghost_motion_unit

Overview:
Autonomous red-ghost controller for the Pac-Man video pipeline. A free-running one-second tick generator, an LFSR-based random direction picker and a frame-stepped position engine with wall blocking live in one block. The block outputs ghost centre/size to the sprite renderer and the current direction keycode to debug/overlay logic.

Parameters:
CLK_HZ, 50000000, Clk cycles per second tick (set small, e.g. 8, in simulation)
START_X, 320, ghost centre X after reset/lifeDown/restart
START_Y, 240, ghost centre Y after reset/lifeDown/restart
SIZE, 13, ghost half-size in pixels
STEP, 1, pixels moved per frame tick
X_MAX, 639, rightmost pixel column
Y_MAX, 479, bottom pixel row
LFSR_SEED, 16'hACE1, LFSR value after reset (must be nonzero)

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  one clock; reset is synchronous and active-low
frame_clk  in  1  vertical-sync/frame strobe; rising edge detected in Clk domain
lifeDown  in  1  Pac-Man lost a life; return ghost to start
restart  in  1  game restart; return ghost to start
mapL  in  5  wall probes along left edge; any bit set = left blocked
mapR  in  5  wall probes along right edge; any bit set = right blocked
mapT  in  5  wall probes along top edge; any bit set = up blocked
mapB  in  5  wall probes along bottom edge; any bit set = down blocked
redghostX  out  10  ghost centre X
redghostY  out  10  ghost centre Y
redghostS  out  10  ghost half-size, constant SIZE
randomkeycode  out  8  current direction as USB keycode
sec  out  1  one-Clk pulse once per second
counter_out  out  32  live value of the second counter

Behaviour:
- All state updates on the rising edge of Clk. When Reset is low on an edge, every register takes its reset value. Reset has priority over all other inputs.
- Second counter:
  - Reset: counter_out=0, sec=0.
  - Each cycle: if counter_out==CLK_HZ-1, then counter_out<=0 and sec<=1. Otherwise counter_out<=counter_out+1 and sec<=0.
  - sec is registered. It pulses high for exactly one cycle, every CLK_HZ cycles. The first pulse is in the cycle CLK_HZ cycles after reset release.
- Random direction:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11 (x^16+x^14+x^13+x^11+1). It shifts every Clk cycle. Reset loads LFSR_SEED.
  - On a cycle where sec==1, randomkeycode latches from LFSR[1:0]: 00->8'h1A (up), 01->8'h04 (left), 10->8'h16 (down), 11->8'h07 (right).
  - Reset: randomkeycode=8'h07. Between sec pulses randomkeycode holds its value.
- Frame tick: register frame_clk as frame_d. The move strobe is frame_clk & ~frame_d, one cycle per rising edge. A frame_clk held constant produces no movement. Reset: frame_d=0.
- Position engine:
  - Reset, or lifeDown==1, or restart==1: redghostX=START_X, redghostY=START_Y. lifeDown and restart are synchronous, level-sensitive and override the move strobe.
  - On the move strobe, the ghost moves by STEP along the direction in randomkeycode (up: Y-=STEP, down: Y+=STEP, left: X-=STEP, right: X+=STEP) unless:
    - (a) the matching map vector is nonzero (blocked), in which case the position holds; or
    - (b) the move would place the edge outside the screen. X must stay in [SIZE, X_MAX-SIZE] and Y in [SIZE, Y_MAX-SIZE]; when outside, the position clamps to the bound.
  - An unrecognised keycode holds the position.
  - Only the map vector for the current direction matters. The other three are ignored.
  - redghostS is driven constantly with SIZE.
- Arithmetic is 10-bit unsigned. Clamp checks are done before subtraction so the value never wraps below 0.
- Simultaneous sec and move strobe: the move uses the pre-update randomkeycode, and the new direction applies from the next strobe.

Test Plan:
- CLK_HZ=8. Release Reset -> counter_out counts 0..7. sec is high for one cycle when the count wraps, repeating every 8 cycles. Reset low mid-count -> counter_out=0 and sec=0 on the next edge.
- After reset -> randomkeycode=8'h07. On each sec pulse randomkeycode becomes the keycode mapped from LFSR[1:0]. The sequence is compared against a reference LFSR seeded 16'hACE1, and it stays constant between pulses.
- Maps all 0, direction right (8'h07), 5 frame_clk rising edges -> redghostX=325, redghostY=240, redghostS=13.
- Direction right, mapR=5'b00100, 3 frame edges -> redghostX unchanged. mapL nonzero alone with direction right -> ghost still moves.
- frame_clk held high for 100 cycles (one rising edge) -> exactly one STEP of movement.
- Ghost at X=20 moving left for 10 frames -> redghostX stops at 13. Assert lifeDown for 1 cycle -> position is (320,240) on the next edge, overriding a simultaneous frame edge.
